// File: rtl/seg_pattern_encoder.sv
// Debounces a 7-bit active-low segment pattern and encodes it back to a hex digit.
// Reports commit status through digit_valid, digit_new, blank, pattern_err and a saturating error count.
module seg_pattern_encoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       seg_in,
    input  logic             clear_err,
    output logic [3:0]       digit,
    output logic             digit_valid,
    output logic             digit_new,
    output logic             blank,
    output logic             pattern_err,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0]       IDLE      = 2'd0;
    localparam logic [1:0]       SETTLE    = 2'd1;
    localparam logic [1:0]       LOCKED    = 2'd2;
    localparam logic [6:0]       BLANK_PAT = 7'h7F;
    localparam logic [CNT_W-1:0] STABLE_N  = CNT_W'(STABLE_CYCLES);

    logic [6:0]       seg_q;
    logic [6:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       state_q, state_d;
    logic [3:0]       digit_q, digit_d;
    logic             valid_q, valid_d;
    logic             new_q, new_d;
    logic             blank_q, blank_d;
    logic             perr_q, perr_d;
    logic [ERR_W-1:0] errc_q, errc_d;
    logic             commit;
    logic             legal;
    logic [3:0]       code;

    // Returns {legal, code} for an active-low gfedcba pattern.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b1000000: decode = {1'b1, 4'h0};
            7'b1111001: decode = {1'b1, 4'h1};
            7'b0100100: decode = {1'b1, 4'h2};
            7'b0110000: decode = {1'b1, 4'h3};
            7'b0011001: decode = {1'b1, 4'h4};
            7'b0010010: decode = {1'b1, 4'h5};
            7'b0000010: decode = {1'b1, 4'h6};
            7'b1111000: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0011000: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b0000011: decode = {1'b1, 4'hB};
            7'b1000110: decode = {1'b1, 4'hC};
            7'b0100001: decode = {1'b1, 4'hD};
            7'b0000110: decode = {1'b1, 4'hE};
            7'b0001110: decode = {1'b1, 4'hF};
            default:    decode = {1'b0, 4'h0};
        endcase
    endfunction

    assign {legal, code} = decode(seg_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q   <= BLANK_PAT;
            cand_q  <= BLANK_PAT;
            cnt_q   <= '0;
            state_q <= IDLE;
            digit_q <= '0;
            valid_q <= 1'b0;
            new_q   <= 1'b0;
            blank_q <= 1'b0;
            perr_q  <= 1'b0;
            errc_q  <= '0;
        end else begin
            seg_q   <= seg_in;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            digit_q <= digit_d;
            valid_q <= valid_d;
            new_q   <= new_d;
            blank_q <= blank_d;
            perr_q  <= perr_d;
            errc_q  <= errc_d;
        end
    end

    // Stability tracking: cnt counts samples matching the candidate, including the one that loaded it.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                cand_d  = seg_q;
                cnt_d   = CNT_W'(1);
                state_d = SETTLE;
            end
            SETTLE: begin
                if (seg_q != cand_q) begin
                    cand_d = seg_q;
                    cnt_d  = CNT_W'(1);
                end else if (cnt_q == STABLE_N) begin
                    commit  = 1'b1;
                    state_d = LOCKED;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            LOCKED: begin
                if (seg_q != cand_q) begin
                    cand_d  = seg_q;
                    cnt_d   = CNT_W'(1);
                    state_d = SETTLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Commit actions; pulses default low so they last exactly one cycle.
    always_comb begin
        digit_d = digit_q;
        valid_d = valid_q;
        new_d   = 1'b0;
        blank_d = blank_q;
        perr_d  = 1'b0;
        errc_d  = errc_q;
        if (commit) begin
            if (legal) begin
                digit_d = code;
                valid_d = 1'b1;
                blank_d = 1'b0;
                new_d   = !valid_q || (code != digit_q);
            end else if (seg_q == BLANK_PAT) begin
                valid_d = 1'b0;
                blank_d = 1'b1;
            end else begin
                perr_d  = 1'b1;
                valid_d = 1'b0;
                blank_d = 1'b0;
                if (errc_q != {ERR_W{1'b1}}) begin
                    errc_d = errc_q + ERR_W'(1);
                end
            end
        end
        if (clear_err) begin
            errc_d = '0;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign digit_new   = new_q;
    assign blank       = blank_q;
    assign pattern_err = perr_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_seg_pattern_encoder.sv
// Bench for seg_pattern_encoder: run-length reference model checked every cycle plus directed literal checks.
module tb_seg_pattern_encoder;

    localparam int S = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] seg_in;
    logic       clear_err;
    logic [3:0] digit;
    logic       digit_valid;
    logic       digit_new;
    logic       blank;
    logic       pattern_err;
    logic [7:0] err_count;

    int checks = 0;
    int errors = 0;

    seg_pattern_encoder #(.STABLE_CYCLES(S), .CNT_W(8), .ERR_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .seg_in     (seg_in),
        .clear_err  (clear_err),
        .digit      (digit),
        .digit_valid(digit_valid),
        .digit_new  (digit_new),
        .blank      (blank),
        .pattern_err(pattern_err),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: a pattern commits when it is the (S+1)th consecutive equal sample seen after reset.
    bit         m_init = 1'b0;
    logic [6:0] m_s, m_last;
    int         m_run;
    logic [3:0] m_digit;
    logic       m_valid, m_new, m_blank, m_err;
    int         m_cnt;

    int         run_next;
    logic       m_legal;
    logic [3:0] m_idx;

    always @* begin
        if (m_run == 0)
            run_next = 1;
        else if (m_s == m_last)
            run_next = (m_run >= S + 2) ? m_run : m_run + 1;
        else
            run_next = 1;
        m_legal = 1'b0;
        m_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (tbl[i] == m_s) begin
                m_legal = 1'b1;
                m_idx   = 4'(i);
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            m_init  <= 1'b1;
            m_s     <= 7'h7F;
            m_last  <= 7'h7F;
            m_run   <= 0;
            m_digit <= 4'd0;
            m_valid <= 1'b0;
            m_new   <= 1'b0;
            m_blank <= 1'b0;
            m_err   <= 1'b0;
            m_cnt   <= 0;
        end else begin
            m_s    <= seg_in;
            m_last <= m_s;
            m_run  <= run_next;
            m_new  <= 1'b0;
            m_err  <= 1'b0;
            if (run_next == S + 1) begin
                if (m_legal) begin
                    m_digit <= m_idx;
                    m_valid <= 1'b1;
                    m_blank <= 1'b0;
                    m_new   <= !m_valid || (m_idx != m_digit);
                end else if (m_s == 7'h7F) begin
                    m_valid <= 1'b0;
                    m_blank <= 1'b1;
                end else begin
                    m_err   <= 1'b1;
                    m_valid <= 1'b0;
                    m_blank <= 1'b0;
                    if (!clear_err) m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
                end
            end
            if (clear_err) m_cnt <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_init) begin
            chk("model_digit", int'(digit), int'(m_digit));
            chk("model_valid", int'(digit_valid), int'(m_valid));
            chk("model_new", int'(digit_new), int'(m_new));
            chk("model_blank", int'(blank), int'(m_blank));
            chk("model_perr", int'(pattern_err), int'(m_err));
            chk("model_errcnt", int'(err_count), m_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        seg_in    = 7'h7F;
        clear_err = 1'b0;
        tick(2);
        chk("rst_digit", int'(digit), 0);
        chk("rst_valid", int'(digit_valid), 0);
        chk("rst_blank", int'(blank), 0);
        chk("rst_errcnt", int'(err_count), 0);

        // Commit of 3 lands exactly at E0+5.
        rst    = 1'b0;
        seg_in = 7'b0110000;
        tick(5);
        chk("t1_early_valid", int'(digit_valid), 0);
        chk("t1_early_new", int'(digit_new), 0);
        tick(1);
        chk("t1_digit", int'(digit), 3);
        chk("t1_valid", int'(digit_valid), 1);
        chk("t1_new", int'(digit_new), 1);
        chk("t1_errcnt", int'(err_count), 0);
        tick(1);
        chk("t1_new_drop", int'(digit_new), 0);

        // Two-cycle glitch to 5 is rejected.
        seg_in = 7'b0010010;
        tick(2);
        seg_in = 7'b0110000;
        tick(8);
        chk("t2_digit", int'(digit), 3);
        chk("t2_valid", int'(digit_valid), 1);

        // Blank then 8.
        seg_in = 7'b1111111;
        tick(6);
        chk("t3_blank", int'(blank), 1);
        chk("t3_valid", int'(digit_valid), 0);
        chk("t3_digit_hold", int'(digit), 3);
        seg_in = 7'b0000000;
        tick(6);
        chk("t3_digit8", int'(digit), 8);
        chk("t3_new8", int'(digit_new), 1);
        chk("t3_blank_off", int'(blank), 0);
        chk("t3_valid8", int'(digit_valid), 1);

        // Illegal commits and saturation.
        seg_in = 7'b1010101;
        tick(6);
        chk("t4_perr", int'(pattern_err), 1);
        chk("t4_errcnt1", int'(err_count), 1);
        chk("t4_valid", int'(digit_valid), 0);
        tick(1);
        chk("t4_perr_drop", int'(pattern_err), 0);
        for (int k = 0; k < 255; k++) begin
            seg_in = 7'b0000000;
            tick(6);
            seg_in = 7'b1010101;
            tick(6);
        end
        chk("t4_errcnt_sat", int'(err_count), 255);

        // clear_err coinciding with an illegal commit.
        seg_in = 7'b0000000;
        tick(6);
        seg_in = 7'b1010101;
        tick(5);
        clear_err = 1'b1;
        tick(1);
        clear_err = 1'b0;
        chk("t5_perr", int'(pattern_err), 1);
        chk("t5_errcnt", int'(err_count), 0);
        tick(1);

        // Reset in the middle of settling on a new candidate.
        seg_in = 7'b1111001;
        tick(3);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_digit", int'(digit), 0);
        chk("t6_rst_valid", int'(digit_valid), 0);
        chk("t6_rst_new", int'(digit_new), 0);
        chk("t6_rst_perr", int'(pattern_err), 0);
        chk("t6_rst_blank", int'(blank), 0);
        rst = 1'b0;
        tick(5);
        chk("t6_early_new", int'(digit_new), 0);
        chk("t6_early_valid", int'(digit_valid), 0);
        tick(1);
        chk("t6_digit1", int'(digit), 1);
        chk("t6_new1", int'(digit_new), 1);
        chk("t6_valid1", int'(digit_valid), 1);
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
